// File: rtl/dm_cache_pkg.sv
// dm_cache_pkg: shared definitions for the direct-mapped cache controller.
//   - Geometry: word address width, word width, block and line counts.
//   - Derived field widths: OFF_W, IDX_W, TAG_W, and LINE_W (one block).
//   - Controller FSM state enum.
//   - Helpers to split a word address into tag/idx/off, to form a
//     block-aligned address, and to select one word out of a block.
package dm_cache_pkg;

    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 32;
    localparam int BLK_WORDS = 4;
    localparam int NUM_BLKS  = 1024;

    localparam int OFF_W  = $clog2(BLK_WORDS);
    localparam int IDX_W  = $clog2(NUM_BLKS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = BLK_WORDS * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MEM_RD = 2'd1,
        ST_MEM_WR = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return a[OFF_W +: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
        return a[OFF_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] blk_base(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

    // Word 0 of a block sits in the least significant bits.
    function automatic logic [DATA_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [OFF_W-1:0]  off);
        return line[int'(off)*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/dm_cache_ctrl_array.sv
// dm_cache_array: valid/tag/data storage for the direct-mapped cache.
//   rd_idx_i                     -> rd_valid_o, rd_tag_o, rd_line_o (combinational lookup)
//   fill_en_i/fill_idx_i/fill_tag_i/fill_line_i : whole-line fill, sets tag and valid
//   wr_en_i/wr_idx_i/wr_off_i/wr_data_i         : single-word update of a resident line
//   rst clears every valid bit asynchronously; tag and data storage are not reset.
module dm_cache_array
    import dm_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [LINE_W-1:0] rd_line_o,
    input  logic              fill_en_i,
    input  logic [IDX_W-1:0]  fill_idx_i,
    input  logic [TAG_W-1:0]  fill_tag_i,
    input  logic [LINE_W-1:0] fill_line_i,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [OFF_W-1:0]  wr_off_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    logic [NUM_BLKS-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q  [NUM_BLKS];
    logic [LINE_W-1:0]   data_q [NUM_BLKS];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_line_o  = data_q[rd_idx_i];

    // Valid bits: cleared by reset, set by a line fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_en_i) begin
            valid_q[fill_idx_i] <= 1'b1;
        end
    end

    // Tag and data storage; fill and word write are never requested together.
    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            tag_q[fill_idx_i]  <= fill_tag_i;
            data_q[fill_idx_i] <= fill_line_i;
        end else if (wr_en_i) begin
            data_q[wr_idx_i][int'(wr_off_i)*DATA_W +: DATA_W] <= wr_data_i;
        end
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, write-through, no-write-allocate cache controller.
//   CPU side : cache_read/cache_write/address/write_data in, cache_ready/read_data out
//              (cache_ready is a one-cycle completion pulse).
//   Memory   : mem_read (block fetch, block-aligned mem_addr) / mem_write (word,
//              mem_addr/mem_wdata) held until mem_ready; mem_rdata is one block.
//   Optional : DM_CACHE_STATS_EN adds saturating hit_count/miss_count outputs that
//              count completed reads.
//   All outputs are registered; rst is asynchronous, active-high.
module dm_cache_ctrl
    import dm_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
`ifdef DM_CACHE_STATS_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
`endif
    input  logic              cache_read,
    input  logic              cache_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic              cache_ready,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata
);

    state_e            state_q;
    logic              ready_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mrd_q;
    logic              mwr_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [DATA_W-1:0] mwdata_q;

    logic [TAG_W-1:0]  req_tag_s;
    logic [IDX_W-1:0]  req_idx_s;
    logic [OFF_W-1:0]  req_off_s;
    logic              rd_valid_s;
    logic [TAG_W-1:0]  rd_tag_s;
    logic [LINE_W-1:0] rd_line_s;
    logic              hit_s;
    logic              fill_en_s;
    logic              wr_en_s;

    assign req_tag_s = addr_tag(address);
    assign req_idx_s = addr_idx(address);
    assign req_off_s = addr_off(address);
    assign hit_s     = rd_valid_s && (rd_tag_s == req_tag_s);
    // Fill only from MEM_RD; rst forces IDLE so a fill in flight never lands.
    assign fill_en_s = (state_q == ST_MEM_RD) && mem_ready;
    // A write hit updates the line on the edge that enters MEM_WR; reads take priority.
    assign wr_en_s   = (state_q == ST_IDLE) && !cache_read && cache_write && hit_s;

    dm_cache_array u_array (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (req_idx_s),
        .rd_valid_o  (rd_valid_s),
        .rd_tag_o    (rd_tag_s),
        .rd_line_o   (rd_line_s),
        .fill_en_i   (fill_en_s),
        .fill_idx_i  (addr_idx(maddr_q)),
        .fill_tag_i  (addr_tag(maddr_q)),
        .fill_line_i (mem_rdata),
        .wr_en_i     (wr_en_s),
        .wr_idx_i    (req_idx_s),
        .wr_off_i    (req_off_s),
        .wr_data_i   (write_data)
    );

    // Controller FSM with registered CPU and memory outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            mrd_q    <= 1'b0;
            mwr_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cache_read) begin
                        if (hit_s) begin
                            ready_q <= 1'b1;
                            rdata_q <= line_word(rd_line_s, req_off_s);
                            state_q <= ST_RESP;
                        end else begin
                            mrd_q   <= 1'b1;
                            maddr_q <= blk_base(address);
                            state_q <= ST_MEM_RD;
                        end
                    end else if (cache_write) begin
                        mwr_q    <= 1'b1;
                        maddr_q  <= address;
                        mwdata_q <= write_data;
                        state_q  <= ST_MEM_WR;
                    end
                end
                ST_MEM_RD: begin
                    if (mem_ready) begin
                        mrd_q   <= 1'b0;
                        ready_q <= 1'b1;
                        rdata_q <= line_word(mem_rdata, req_off_s);
                        state_q <= ST_RESP;
                    end
                end
                ST_MEM_WR: begin
                    if (mem_ready) begin
                        mwr_q   <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Requests are not sampled here, so a held request cannot re-fire.
                    ready_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    mrd_q   <= 1'b0;
                    mwr_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cache_ready = ready_q;
    assign read_data   = rdata_q;
    assign mem_read    = mrd_q;
    assign mem_write   = mwr_q;
    assign mem_addr    = maddr_q;
    assign mem_wdata   = mwdata_q;

`ifdef DM_CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic        hit_evt_s;
    logic        miss_evt_s;

    assign hit_evt_s  = (state_q == ST_IDLE) && cache_read && hit_s;
    assign miss_evt_s = fill_en_s;

    // Saturating read hit/miss counters; each steps on the edge that enters RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            if (hit_evt_s && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_evt_s && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl. The reference model tracks which block
// number is resident per line and the contents of main memory; reads always
// expect the current memory word (write-through keeps the cache coherent).
module tb_dm_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         cache_read, cache_write;
    logic [14:0]  address;
    logic [31:0]  write_data;
    logic         cache_ready;
    logic [31:0]  read_data;
    logic         mem_read, mem_write;
    logic [14:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ready;
    logic [127:0] mem_rdata;
`ifdef DM_CACHE_STATS_EN
    logic [31:0]  hit_count, miss_count;
`endif

    int chk_cnt = 0;
    int err_cnt = 0;

    logic [31:0] mem_model [32768];
    int          res_blk   [1024];

    always #5 clk = ~clk;

    dm_cache_ctrl dut (
        .clk         (clk),
        .rst         (rst),
`ifdef DM_CACHE_STATS_EN
        .hit_count   (hit_count),
        .miss_count  (miss_count),
`endif
        .cache_read  (cache_read),
        .cache_write (cache_write),
        .address     (address),
        .write_data  (write_data),
        .cache_ready (cache_ready),
        .read_data   (read_data),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata)
    );

    function automatic bit m_hit(input int a);
        return res_blk[(a / 4) % 1024] == (a / 4);
    endfunction

    task automatic m_read(input int a);
        res_blk[(a / 4) % 1024] = a / 4;
    endtask

    task automatic apply_reset();
        rst = 1'b1; cache_read = 1'b0; cache_write = 1'b0; address = '0;
        write_data = '0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 1024; i++) res_blk[i] = -1;
    endtask

    // Drives one CPU request, plays main memory, and reports what it observed.
    task automatic do_access(input bit rd, input bit wr, input logic [14:0] addr,
                             input logic [31:0] wd, input int lat,
                             output logic [31:0] o_data, output int o_cyc,
                             output bit o_mrd, output bit o_mwr,
                             output logic [14:0] o_maddr, output logic [31:0] o_mwdata,
                             output bit o_stable, output bit o_gap_ok, output bit o_to);
        int wait_cnt;
        bit prev_rdy;
        o_data = '0; o_cyc = 0; o_mrd = 1'b0; o_mwr = 1'b0; o_maddr = '0; o_mwdata = '0;
        o_stable = 1'b1; o_gap_ok = 1'b1; o_to = 1'b1; wait_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        cache_read = rd; cache_write = wr; address = addr; write_data = wd;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            prev_rdy  = mem_ready;
            mem_ready = 1'b0;
            if (cache_ready) begin
                o_data = read_data; o_cyc = c; o_to = 1'b0;
                if ((o_mrd || o_mwr) && !prev_rdy) o_gap_ok = 1'b0;
                break;
            end
            if (mem_read || mem_write) begin
                if (wait_cnt == 0) begin
                    o_maddr = mem_addr; o_mwdata = mem_wdata;
                    o_mrd = mem_read; o_mwr = mem_write;
                end else if (mem_addr !== o_maddr) begin
                    o_stable = 1'b0;
                end
                wait_cnt++;
                if (wait_cnt == lat) begin
                    mem_ready = 1'b1;
                    for (int w = 0; w < 4; w++)
                        mem_rdata[w*32 +: 32] = mem_model[(int'(mem_addr) / 4) * 4 + w];
                end
            end
        end
        cache_read = 1'b0; cache_write = 1'b0;
    endtask

    logic [31:0] r_data, r_wdata;
    int          r_cyc;
    bit          r_mrd, r_mwr, r_stable, r_gap, r_to;
    logic [14:0] r_maddr;

    task automatic test_reset();
        apply_reset();
        chk_cnt++;
        if ({cache_ready, mem_read, mem_write} !== 3'b000) begin
            err_cnt++; $display("FAIL reset_ctl got %b exp 000", {cache_ready, mem_read, mem_write});
        end
        chk_cnt++;
        if ({read_data, mem_addr, mem_wdata} !== 79'd0) begin
            err_cnt++; $display("FAIL reset_data got %h exp 0", {read_data, mem_addr, mem_wdata});
        end
    endtask

    task automatic test_cold_miss();
        do_access(1'b1, 1'b0, 15'd1024, 32'd0, 3, r_data, r_cyc, r_mrd, r_mwr, r_maddr, r_wdata, r_stable, r_gap, r_to);
        chk_cnt++;
        if (r_to || !r_mrd || r_maddr !== 15'd1024) begin
            err_cnt++; $display("FAIL cold_req to=%0b mrd=%0b maddr=%0d exp mrd=1 maddr=1024", r_to, r_mrd, r_maddr);
        end
        chk_cnt++;
        if (!r_gap || !r_stable) begin
            err_cnt++; $display("FAIL cold_timing gap_ok=%0b stable=%0b exp 1 1", r_gap, r_stable);
        end
        chk_cnt++;
        if (r_data !== mem_model[1024]) begin
            err_cnt++; $display("FAIL cold_data got %h exp %h", r_data, mem_model[1024]);
        end
        m_read(1024);
    endtask

    task automatic test_hit();
        do_access(1'b1, 1'b0, 15'd1025, 32'd0, 3, r_data, r_cyc, r_mrd, r_mwr, r_maddr, r_wdata, r_stable, r_gap, r_to);
        chk_cnt++;
        if (r_to || r_mrd || r_cyc != 1) begin
            err_cnt++; $display("FAIL hit_lat to=%0b mrd=%0b cyc=%0d exp 0 0 1", r_to, r_mrd, r_cyc);
        end
        chk_cnt++;
        if (r_data !== mem_model[1025]) begin
            err_cnt++; $display("FAIL hit_data got %h exp %h", r_data, mem_model[1025]);
        end
        @(posedge clk);
        #1;
        chk_cnt++;
        if (cache_ready !== 1'b0) begin
            err_cnt++; $display("FAIL ready_pulse got %b exp 0", cache_ready);
        end
        m_read(1025);
    endtask

    task automatic test_conflict();
        int misses;
        int seq [3] = '{1024, 5120, 1024};
        apply_reset();
        misses = 0;
        for (int i = 0; i < 3; i++) begin
            do_access(1'b1, 1'b0, 15'(seq[i]), 32'd0, 2, r_data, r_cyc, r_mrd, r_mwr, r_maddr, r_wdata, r_stable, r_gap, r_to);
            misses += int'(r_mrd);
            chk_cnt++;
            if (r_to || r_data !== mem_model[seq[i]]) begin
                err_cnt++; $display("FAIL conflict_data i=%0d got %h exp %h", i, r_data, mem_model[seq[i]]);
            end
            m_read(seq[i]);
        end
        chk_cnt++;
        if (misses != 3) begin
            err_cnt++; $display("FAIL conflict_misses got %0d exp 3", misses);
        end
    endtask

    task automatic test_write_hit();
        do_access(1'b0, 1'b1, 15'd1025, 32'hDEADBEEF, 2, r_data, r_cyc, r_mrd, r_mwr, r_maddr, r_wdata, r_stable, r_gap, r_to);
        chk_cnt++;
        if (r_to || !r_mwr || r_mrd || r_maddr !== 15'd1025 || r_wdata !== 32'hDEADBEEF) begin
            err_cnt++; $display("FAIL wr_hit_req mwr=%0b mrd=%0b maddr=%0d wdata=%h exp 1 0 1025 deadbeef",
                                r_mwr, r_mrd, r_maddr, r_wdata);
        end
        mem_model[1025] = 32'hDEADBEEF;
        do_access(1'b1, 1'b0, 15'd1025, 32'd0, 2, r_data, r_cyc, r_mrd, r_mwr, r_maddr, r_wdata, r_stable, r_gap, r_to);
        chk_cnt++;
        if (r_to || r_mrd || r_data !== 32'hDEADBEEF) begin
            err_cnt++; $display("FAIL wr_hit_readback mrd=%0b got %h exp mrd=0 deadbeef", r_mrd, r_data);
        end
    endtask

    task automatic test_write_miss();
        do_access(1'b0, 1'b1, 15'd2048, 32'h0BAD_F00D, 1, r_data, r_cyc, r_mrd, r_mwr, r_maddr, r_wdata, r_stable, r_gap, r_to);
        chk_cnt++;
        if (r_to || !r_mwr || r_maddr !== 15'd2048) begin
            err_cnt++; $display("FAIL wr_miss_req mwr=%0b maddr=%0d exp 1 2048", r_mwr, r_maddr);
        end
        mem_model[2048] = 32'h0BAD_F00D;
        do_access(1'b1, 1'b0, 15'd2048, 32'd0, 1, r_data, r_cyc, r_mrd, r_mwr, r_maddr, r_wdata, r_stable, r_gap, r_to);
        chk_cnt++;
        if (r_to || !r_mrd || r_maddr !== 15'd2048 || r_data !== 32'h0BAD_F00D) begin
            err_cnt++; $display("FAIL wr_miss_noalloc mrd=%0b maddr=%0d data=%h exp 1 2048 0badf00d",
                                r_mrd, r_maddr, r_data);
        end
        m_read(2048);
    endtask

    task automatic test_rd_wr_both();
        bit exp_hit;
        exp_hit = m_hit(1026);
        do_access(1'b1, 1'b1, 15'd1026, 32'h1234_5678, 2, r_data, r_cyc, r_mrd, r_mwr, r_maddr, r_wdata, r_stable, r_gap, r_to);
        chk_cnt++;
        if (r_to || r_mwr || r_mrd == exp_hit || r_data !== mem_model[1026]) begin
            err_cnt++; $display("FAIL rd_wr_both mwr=%0b mrd=%0b data=%h exp 0 %0b %h",
                                r_mwr, r_mrd, r_data, !exp_hit, mem_model[1026]);
        end
        m_read(1026);
    endtask

    task automatic test_top_addr();
        do_access(1'b1, 1'b0, 15'd32767, 32'd0, 2, r_data, r_cyc, r_mrd, r_mwr, r_maddr, r_wdata, r_stable, r_gap, r_to);
        chk_cnt++;
        if (r_to || r_mrd == m_hit(32767) || r_maddr !== 15'd32764 || r_data !== mem_model[32767]) begin
            err_cnt++; $display("FAIL top_miss mrd=%0b maddr=%0d data=%h exp maddr=32764 %h",
                                r_mrd, r_maddr, r_data, mem_model[32767]);
        end
        m_read(32767);
        do_access(1'b1, 1'b0, 15'd32764, 32'd0, 2, r_data, r_cyc, r_mrd, r_mwr, r_maddr, r_wdata, r_stable, r_gap, r_to);
        chk_cnt++;
        if (r_to || r_mrd || r_data !== mem_model[32764]) begin
            err_cnt++; $display("FAIL top_hit mrd=%0b data=%h exp 0 %h", r_mrd, r_data, mem_model[32764]);
        end
    endtask

    task automatic test_back_to_back();
        int seq [4] = '{4097, 4098, 4099, 4096};
        int k, last;
        bit saw_mrd;
        do_access(1'b1, 1'b0, 15'd4096, 32'd0, 1, r_data, r_cyc, r_mrd, r_mwr, r_maddr, r_wdata, r_stable, r_gap, r_to);
        m_read(4096);
        k = 0; last = 0; saw_mrd = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cache_read = 1'b1; address = 15'(seq[0]);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (mem_read) saw_mrd = 1'b1;
            if (cache_ready) begin
                chk_cnt++;
                if (read_data !== mem_model[seq[k]]) begin
                    err_cnt++; $display("FAIL b2b_data k=%0d got %h exp %h", k, read_data, mem_model[seq[k]]);
                end
                if (k > 0) begin
                    chk_cnt++;
                    if (c - last != 2) begin
                        err_cnt++; $display("FAIL b2b_spacing k=%0d got %0d exp 2", k, c - last);
                    end
                end
                last = c;
                k++;
                if (k == 4) break;
                address = 15'(seq[k]);
            end
        end
        cache_read = 1'b0;
        chk_cnt++;
        if (k != 4 || saw_mrd) begin
            err_cnt++; $display("FAIL b2b_done responses=%0d mem_read=%0b exp 4 0", k, saw_mrd);
        end
    endtask

    task automatic test_reset_midfill();
        bit seen;
        seen = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cache_read = 1'b1; address = 15'd3000;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (mem_read) begin seen = 1'b1; break; end
        end
        chk_cnt++;
        if (!seen) begin
            err_cnt++; $display("FAIL midfill_req mem_read not seen exp 1");
        end
        #2;
        rst = 1'b1;
        mem_ready = 1'b1;
        for (int w = 0; w < 4; w++) mem_rdata[w*32 +: 32] = mem_model[3000 + w];
        #1;
        chk_cnt++;
        if (mem_read !== 1'b0 || cache_ready !== 1'b0) begin
            err_cnt++; $display("FAIL midfill_async mem_read=%b cache_ready=%b exp 0 0", mem_read, cache_ready);
        end
        cache_read = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 1024; i++) res_blk[i] = -1;
        do_access(1'b1, 1'b0, 15'd1024, 32'd0, 2, r_data, r_cyc, r_mrd, r_mwr, r_maddr, r_wdata, r_stable, r_gap, r_to);
        chk_cnt++;
        if (r_to || !r_mrd || r_data !== mem_model[1024]) begin
            err_cnt++; $display("FAIL midfill_after1024 mrd=%0b data=%h exp 1 %h", r_mrd, r_data, mem_model[1024]);
        end
        m_read(1024);
        do_access(1'b1, 1'b0, 15'd3000, 32'd0, 2, r_data, r_cyc, r_mrd, r_mwr, r_maddr, r_wdata, r_stable, r_gap, r_to);
        chk_cnt++;
        if (r_to || !r_mrd) begin
            err_cnt++; $display("FAIL midfill_not_written mrd=%0b exp 1", r_mrd);
        end
        m_read(3000);
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            int a, op, lat;
            bit rd, wr, hit;
            logic [31:0] wd;
            a   = $urandom_range(0, 7) * 4096 + $urandom_range(0, 7) * 4 + $urandom_range(0, 3);
            op  = $urandom_range(0, 9);
            rd  = (op < 6) || (op == 9);
            wr  = (op >= 6);
            wd  = $urandom;
            lat = $urandom_range(1, 4);
            hit = m_hit(a);
            do_access(rd, wr, 15'(a), wd, lat, r_data, r_cyc, r_mrd, r_mwr, r_maddr, r_wdata, r_stable, r_gap, r_to);
            chk_cnt++;
            if (r_to || !r_stable) begin
                err_cnt++; $display("FAIL rnd_handshake n=%0d to=%0b stable=%0b", n, r_to, r_stable);
            end
            if (rd) begin
                chk_cnt++;
                if (r_data !== mem_model[a]) begin
                    err_cnt++; $display("FAIL rnd_data n=%0d a=%0d got %h exp %h", n, a, r_data, mem_model[a]);
                end
                chk_cnt++;
                if (r_mrd == hit || r_mwr) begin
                    err_cnt++; $display("FAIL rnd_hitmiss n=%0d a=%0d mrd=%0b mwr=%0b exp mrd=%0b", n, a, r_mrd, r_mwr, !hit);
                end
                chk_cnt++;
                if (hit ? (r_cyc != 1) : (!r_gap || r_maddr !== 15'(a - a % 4))) begin
                    err_cnt++; $display("FAIL rnd_rdtiming n=%0d cyc=%0d gap=%0b maddr=%0d", n, r_cyc, r_gap, r_maddr);
                end
                m_read(a);
            end else begin
                chk_cnt++;
                if (!r_mwr || r_mrd || r_maddr !== 15'(a) || r_wdata !== wd || !r_gap) begin
                    err_cnt++; $display("FAIL rnd_write n=%0d mwr=%0b mrd=%0b maddr=%0d wdata=%h exp 1 0 %0d %h",
                                        n, r_mwr, r_mrd, r_maddr, r_wdata, a, wd);
                end
                mem_model[a] = wd;
            end
        end
    endtask

`ifdef DM_CACHE_STATS_EN
    task automatic test_stats();
        int exp_h, exp_m;
        apply_reset();
        exp_h = 0; exp_m = 0;
        chk_cnt++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            err_cnt++; $display("FAIL stats_reset hit=%0d miss=%0d exp 0 0", hit_count, miss_count);
        end
        for (int i = 0; i < 8192; i++) begin
            if (m_hit(1024 + i)) exp_h++; else exp_m++;
            do_access(1'b1, 1'b0, 15'(1024 + i), 32'd0, 1, r_data, r_cyc, r_mrd, r_mwr, r_maddr, r_wdata, r_stable, r_gap, r_to);
            m_read(1024 + i);
        end
        chk_cnt++;
        if (hit_count !== 32'(exp_h) || miss_count !== 32'(exp_m) || exp_h != 6144 || exp_m != 2048) begin
            err_cnt++; $display("FAIL stats_counts hit=%0d miss=%0d exp %0d %0d", hit_count, miss_count, exp_h, exp_m);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 32768; i++) mem_model[i] = $urandom;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_write_hit();
        test_write_miss();
        test_rd_wr_both();
        test_top_addr();
        test_back_to_back();
        test_reset_midfill();
        test_random();
`ifdef DM_CACHE_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
